// File: rtl/ex_mem_if.sv
// rtl/ex_mem_if.sv - EX/MEM pipeline register signal bundle
interface ex_mem_if;
  // Stage control
  logic        stall_ex;
  logic        stall_mem;
  logic        flush;
  // EX-side inputs
  logic [4:0]  ex_write_addr;
  logic        ex_write_enable;
  logic [31:0] ex_write_data;
  logic        ex_write_hilo_enable;
  logic [31:0] ex_write_hi_data;
  logic [31:0] ex_write_lo_data;
  logic [63:0] ex_hilo_temp;
  logic [1:0]  ex_cycle;
  // MEM-side outputs
  logic [4:0]  mem_write_addr;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic        mem_write_hilo_enable;
  logic [31:0] mem_write_hi_data;
  logic [31:0] mem_write_lo_data;
  logic        mem_valid;
  logic [63:0] hilo_temp_out;
  logic [1:0]  cycle_out;

  // Pipeline control / EX stage side: drives controls and EX results, observes MEM
  modport master (
    output stall_ex, stall_mem, flush,
    output ex_write_addr, ex_write_enable, ex_write_data,
    output ex_write_hilo_enable, ex_write_hi_data, ex_write_lo_data,
    output ex_hilo_temp, ex_cycle,
    input  mem_write_addr, mem_write_enable, mem_write_data,
    input  mem_write_hilo_enable, mem_write_hi_data, mem_write_lo_data,
    input  mem_valid, hilo_temp_out, cycle_out
  );

  // The EX/MEM register itself
  modport slave (
    input  stall_ex, stall_mem, flush,
    input  ex_write_addr, ex_write_enable, ex_write_data,
    input  ex_write_hilo_enable, ex_write_hi_data, ex_write_lo_data,
    input  ex_hilo_temp, ex_cycle,
    output mem_write_addr, mem_write_enable, mem_write_data,
    output mem_write_hilo_enable, mem_write_hi_data, mem_write_lo_data,
    output mem_valid, hilo_temp_out, cycle_out
  );
endinterface

// File: rtl/ex_mem.sv
// rtl/ex_mem.sv - EX/MEM pipeline register; EX_MEM_MULTICYCLE_EN enables the multi-cycle feedback path
module ex_mem (
  input  logic     clock,
  input  logic     reset,
  ex_mem_if.slave  bus
);

  logic [4:0]  wr_addr_q,  wr_addr_d;
  logic        wr_en_q,    wr_en_d;
  logic [31:0] wr_data_q,  wr_data_d;
  logic        hilo_en_q,  hilo_en_d;
  logic [31:0] hi_data_q,  hi_data_d;
  logic [31:0] lo_data_q,  lo_data_d;
  logic        valid_q,    valid_d;

  // Advance only when neither stage is stalled; stall_mem alone (illegal) falls into hold.
  logic advance;
  logic bubble;
  assign advance = !bus.stall_ex && !bus.stall_mem;
  assign bubble  =  bus.stall_ex && !bus.stall_mem;

  // Next-state for the MEM-facing write fields: flush > bubble > hold > advance
  always_comb begin
    wr_addr_d = wr_addr_q;
    wr_en_d   = wr_en_q;
    wr_data_d = wr_data_q;
    hilo_en_d = hilo_en_q;
    hi_data_d = hi_data_q;
    lo_data_d = lo_data_q;
    valid_d   = valid_q;
    if (bus.flush || bubble) begin
      wr_addr_d = '0;
      wr_en_d   = 1'b0;
      wr_data_d = '0;
      hilo_en_d = 1'b0;
      hi_data_d = '0;
      lo_data_d = '0;
      valid_d   = 1'b0;
    end else if (advance) begin
      wr_addr_d = bus.ex_write_addr;
      wr_en_d   = bus.ex_write_enable;
      wr_data_d = bus.ex_write_data;
      hilo_en_d = bus.ex_write_hilo_enable;
      hi_data_d = bus.ex_write_hi_data;
      lo_data_d = bus.ex_write_lo_data;
      valid_d   = 1'b1;
    end
  end

  // Write-field register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      hilo_en_q <= 1'b0;
      hi_data_q <= '0;
      lo_data_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      wr_addr_q <= wr_addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      hilo_en_q <= hilo_en_d;
      hi_data_q <= hi_data_d;
      lo_data_q <= lo_data_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.mem_write_addr        = wr_addr_q;
  assign bus.mem_write_enable      = wr_en_q;
  assign bus.mem_write_data        = wr_data_q;
  assign bus.mem_write_hilo_enable = hilo_en_q;
  assign bus.mem_write_hi_data     = hi_data_q;
  assign bus.mem_write_lo_data     = lo_data_q;
  assign bus.mem_valid             = valid_q;

`ifdef EX_MEM_MULTICYCLE_EN
  logic [63:0] temp_q, temp_d;
  logic [1:0]  cycle_q, cycle_d;

  // Partial result parks here while EX is stalled and is dropped once the instruction advances
  always_comb begin
    temp_d  = temp_q;
    cycle_d = cycle_q;
    if (bus.flush || advance) begin
      temp_d  = '0;
      cycle_d = '0;
    end else if (bubble) begin
      temp_d  = bus.ex_hilo_temp;
      cycle_d = bus.ex_cycle;
    end
  end

  // Multi-cycle feedback register with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      temp_q  <= '0;
      cycle_q <= '0;
    end else begin
      temp_q  <= temp_d;
      cycle_q <= cycle_d;
    end
  end

  assign bus.hilo_temp_out = temp_q;
  assign bus.cycle_out     = cycle_q;
`else
  // Feature disabled: feedback ports tie off and EX's partial result is discarded
  logic unused_multicycle;
  assign unused_multicycle = ^{bus.ex_hilo_temp, bus.ex_cycle};

  assign bus.hilo_temp_out = '0;
  assign bus.cycle_out     = '0;
`endif

endmodule

// File: tb/tb_ex_mem.sv
// tb/tb_ex_mem.sv - directed self-checking bench for ex_mem
module tb_ex_mem;

`ifdef EX_MEM_MULTICYCLE_EN
  localparam bit MC = 1'b1;
`else
  localparam bit MC = 1'b0;
`endif

  logic clock;
  logic reset;
  int   tests_run;
  int   tests_failed;

  ex_mem_if bus ();

  ex_mem dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_outs(input string t, input logic [4:0] addr, input logic we,
                            input logic [31:0] data, input logic hwe, input logic [31:0] hi,
                            input logic [31:0] lo, input logic valid, input logic [63:0] temp,
                            input logic [1:0] cyc);
    check({t, ".addr"},  64'(bus.mem_write_addr),        64'(addr));
    check({t, ".we"},    64'(bus.mem_write_enable),      64'(we));
    check({t, ".data"},  64'(bus.mem_write_data),        64'(data));
    check({t, ".hwe"},   64'(bus.mem_write_hilo_enable), 64'(hwe));
    check({t, ".hi"},    64'(bus.mem_write_hi_data),     64'(hi));
    check({t, ".lo"},    64'(bus.mem_write_lo_data),     64'(lo));
    check({t, ".valid"}, 64'(bus.mem_valid),             64'(valid));
    check({t, ".temp"},  bus.hilo_temp_out,              temp);
    check({t, ".cycle"}, 64'(bus.cycle_out),             64'(cyc));
  endtask

  task automatic set_ex(input logic [4:0] addr, input logic we, input logic [31:0] data,
                        input logic hwe, input logic [31:0] hi, input logic [31:0] lo,
                        input logic [63:0] temp, input logic [1:0] cyc);
    bus.ex_write_addr        = addr;
    bus.ex_write_enable      = we;
    bus.ex_write_data        = data;
    bus.ex_write_hilo_enable = hwe;
    bus.ex_write_hi_data     = hi;
    bus.ex_write_lo_data     = lo;
    bus.ex_hilo_temp         = temp;
    bus.ex_cycle             = cyc;
  endtask

  task automatic ctl(input logic se, input logic sm, input logic fl);
    bus.stall_ex  = se;
    bus.stall_mem = sm;
    bus.flush     = fl;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    ctl(1'b0, 1'b0, 1'b0);
    set_ex(5'd9, 1'b1, 32'hFFFF_FFFF, 1'b1, 32'h1, 32'h2, 64'h55, 2'd2);

    // Reset dominates a live advance
    step();
    step();
    check_outs("reset", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0);
    reset = 1'b0;

    // Advance: partial-result inputs must not leak through
    set_ex(5'd3, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 64'h77, 2'd3);
    step();
    check_outs("adv", 5'd3, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 1'b1, 64'h0, 2'd0);

    // Hold for 3 cycles while EX inputs change
    ctl(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      set_ex(5'(i + 10), 1'b0, 32'hA0A0_0000 + 32'(i), 1'b1, 32'hF, 32'hE, 64'h99, 2'd1);
      step();
      check_outs($sformatf("hold%0d", i), 5'd3, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 32'h0,
                 1'b1, 64'h0, 2'd0);
    end

    // Illegal stall_mem-only combination behaves as hold
    ctl(1'b0, 1'b1, 1'b0);
    step();
    check_outs("illegal", 5'd3, 1'b1, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 1'b1, 64'h0, 2'd0);

    // HI/LO advance
    ctl(1'b0, 1'b0, 1'b0);
    set_ex(5'd4, 1'b0, 32'h0, 1'b1, 32'hA, 32'hB, 64'h0, 2'd0);
    step();
    check_outs("hilo", 5'd4, 1'b0, 32'h0, 1'b1, 32'hA, 32'hB, 1'b1, 64'h0, 2'd0);

    // Bubble captures partial result
    ctl(1'b1, 1'b0, 1'b0);
    set_ex(5'd5, 1'b1, 32'h5555_5555, 1'b1, 32'hC, 32'hD, 64'hDEAD_BEEF_0000_0001, 2'b01);
    step();
    check_outs("bubble", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0,
               MC ? 64'hDEAD_BEEF_0000_0001 : 64'h0, MC ? 2'd1 : 2'd0);

    // Hold retains the parked partial result
    ctl(1'b1, 1'b1, 1'b0);
    set_ex(5'd6, 1'b1, 32'h6, 1'b1, 32'h6, 32'h6, 64'h1111_2222_3333_4444, 2'd2);
    step();
    check_outs("bhold", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0,
               MC ? 64'hDEAD_BEEF_0000_0001 : 64'h0, MC ? 2'd1 : 2'd0);

    // Reset mid-sequence, then a normal advance
    ctl(1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    step();
    check_outs("rstmid", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0);
    reset = 1'b0;
    ctl(1'b0, 1'b0, 1'b0);
    set_ex(5'd7, 1'b1, 32'hCAFE_F00D, 1'b1, 32'h10, 32'h20, 64'h0, 2'd0);
    step();
    check_outs("postrst", 5'd7, 1'b1, 32'hCAFE_F00D, 1'b1, 32'h10, 32'h20, 1'b1, 64'h0, 2'd0);

    // Flush beats hold
    ctl(1'b1, 1'b1, 1'b1);
    step();
    check_outs("flush", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0);

    // Flush beats bubble too, clearing parked partial result
    ctl(1'b1, 1'b0, 1'b0);
    set_ex(5'd8, 1'b1, 32'h8, 1'b0, 32'h0, 32'h0, 64'hFFFF_0000_FFFF_0000, 2'd3);
    step();
    check_outs("bub3", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0,
               MC ? 64'hFFFF_0000_FFFF_0000 : 64'h0, MC ? 2'd3 : 2'd0);
    ctl(1'b1, 1'b0, 1'b1);
    step();
    check_outs("flushbub", 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0);

    // Advance after a bubble drops the partial result
    ctl(1'b1, 1'b0, 1'b0);
    step();
    ctl(1'b0, 1'b0, 1'b0);
    set_ex(5'd31, 1'b1, 32'h8000_0001, 1'b0, 32'h0, 32'h0, 64'h1, 2'd1);
    step();
    check_outs("advclr", 5'd31, 1'b1, 32'h8000_0001, 1'b0, 32'h0, 32'h0, 1'b1, 64'h0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ex_mem.md
EX_MEM -- requirements
Module: ex_mem

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; all state SHALL update only on the rising edge of clock.
REQ-002 clock  input  1  pipeline clock.
REQ-003 reset  input  1  synchronous active-high reset, sampled on the rising clock edge.
REQ-004 stall_ex  input  1  EX stage is stalled this cycle.
REQ-005 stall_mem  input  1  MEM stage is stalled this cycle.
REQ-006 flush  input  1  squash the register contents (exception/redirect).
REQ-007 ex_write_addr  input  5  destination GPR from EX.
REQ-008 ex_write_enable  input  1  GPR write request from EX.
REQ-009 ex_write_data  input  32  GPR write data from EX.
REQ-010 ex_write_hilo_enable  input  1  HI/LO write request from EX.
REQ-011 ex_write_hi_data / ex_write_lo_data  input  32 each  HI/LO data from EX.
REQ-012 ex_hilo_temp  input  64  partial multi-cycle result from EX.
REQ-013 ex_cycle  input  2  EX multi-cycle step counter.
REQ-014 mem_write_addr, mem_write_enable, mem_write_data  output  5/1/32  registered GPR write to MEM.
REQ-015 mem_write_hilo_enable, mem_write_hi_data, mem_write_lo_data  output  1/32/32  registered HI/LO write to MEM; also the MEM-stage HI/LO forwarding source for EX.
REQ-016 mem_valid  output  1  register holds a real instruction, not a bubble.
REQ-017 hilo_temp_out  output  64  partial result fed back to EX.
REQ-018 cycle_out  output  2  step counter fed back to EX.

Function
REQ-019 Priority per edge: reset > flush > bubble > hold > advance.
REQ-020 Advance (stall_ex=0): all mem_* outputs latch the corresponding ex_* inputs; mem_valid=1; hilo_temp_out=0; cycle_out=0.
REQ-021 Bubble (stall_ex=1, stall_mem=0): mem_write_enable=0, mem_write_hilo_enable=0, mem_valid=0, all data/addr outputs=0; hilo_temp_out latches ex_hilo_temp and cycle_out latches ex_cycle.
REQ-022 Hold (stall_ex=1, stall_mem=1): every output, including hilo_temp_out and cycle_out, retains its value.
REQ-023 stall_ex=0 with stall_mem=1 is illegal; the block SHALL treat it as hold.
REQ-024 Flush: all outputs cleared to 0 in the same edge, including hilo_temp_out and cycle_out, regardless of stall inputs.
REQ-025 Latency: exactly one cycle from EX inputs to mem_* outputs; there is no combinational path from any input to any output.
REQ-026 cycle_out SHALL pass ex_cycle unmodified (no increment); values wrap as supplied by EX.
REQ-027 Enable outputs SHALL never be 1 while mem_valid=0.

Reset
REQ-028 On reset, all outputs SHALL be 0: mem_write_addr=0, mem_write_enable=0, mem_write_data=0, mem_write_hilo_enable=0, mem_write_hi_data=0, mem_write_lo_data=0, mem_valid=0, hilo_temp_out=0, cycle_out=0.
REQ-029 Reset asserted mid-multi-cycle sequence SHALL discard hilo_temp_out and cycle_out; the first cycle after reset deassertion behaves per REQ-019.

Configuration
REQ-030 Macro EX_MEM_MULTICYCLE_EN: when defined, hilo_temp_out and cycle_out behave per REQ-020..REQ-024.
REQ-031 When EX_MEM_MULTICYCLE_EN is undefined, the ports still exist, hilo_temp_out and cycle_out SHALL be constant 0, ex_hilo_temp and ex_cycle SHALL be ignored, and no storage SHALL be inferred for them; all other behaviour is unchanged.

Verification
REQ-032 Advance: ex_write_addr=5'd3, enable=1, data=32'h1234_5678, stall_ex=0 -> next cycle mem_write_addr=3, mem_write_data=32'h1234_5678, mem_valid=1.
REQ-033 Bubble: stall_ex=1, stall_mem=0, ex_hilo_temp=64'hDEAD_BEEF_0000_0001, ex_cycle=2'b01 -> mem_valid=0, mem_write_enable=0, hilo_temp_out=64'hDEAD_BEEF_0000_0001, cycle_out=1 (with macro), and 0 without it.
REQ-034 Hold: after REQ-032, assert stall_ex=stall_mem=1 for 3 cycles while changing ex_* -> outputs stay at 3/32'h1234_5678 throughout.
REQ-035 Flush vs stall: flush=1 with stall_ex=stall_mem=1 and nonzero held state -> all outputs 0 next cycle.
REQ-036 Reset mid-sequence: during a bubble with cycle_out=1, assert reset for one cycle -> all outputs 0; first advance afterwards latches new ex_* values normally.
REQ-037 HI/LO path: ex_write_hilo_enable=1, hi=32'hA, lo=32'hB, stall_ex=0 -> next cycle mem_write_hilo_enable=1, hi=32'hA, lo=32'hB; then bubble -> mem_write_hilo_enable=0.
